// File: rtl/fifo_pkg.sv
// Pointer helpers shared by the read-side empty and write-side full logic of the async FIFO.
package fifo_pkg;

    localparam int MAX_PTR_W = 32;

    typedef logic [MAX_PTR_W-1:0] ptr_word_t;

    // Pointers carry one extra MSB beyond the address so full and empty can be told apart.
    function automatic int ptr_width(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return (b >> 1) ^ b;
    endfunction

    // Zero upper bits contribute nothing to the prefix XOR, so callers may zero-extend and truncate.
    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing clock domains; both stages reset to 0.
module sync_2ff #(
    parameter int WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= d_i;
            stage2_q <= stage1_q;
        end
    end

    assign q_o = stage2_q;

endmodule

// File: rtl/rd_empty_ctrl.sv
// Read-side pointer and registered empty flag of the async FIFO.
// Optional almost-empty / occupancy outputs are built when RD_ALMOST_EMPTY_EN is defined.
module rd_empty_ctrl
    import fifo_pkg::*;
#(
    parameter int a_width = 4
`ifdef RD_ALMOST_EMPTY_EN
    , parameter int AE_THRESH = 2
`endif
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               rd_en,
    input  logic [a_width:0]   wr_ptr,
    output logic [a_width:0]   rd_ptr,
    output logic [a_width-1:0] rd_addr,
    output logic               empty_flag
`ifdef RD_ALMOST_EMPTY_EN
    ,
    output logic               almost_empty,
    output logic [a_width:0]   rd_level
`endif
);

    localparam int PTR_W = ptr_width(a_width);

    logic [PTR_W-1:0] wr_syn_ptr;
    logic [PTR_W-1:0] rd_bin_q, rd_bin_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             empty_q, empty_d;
    logic             rd_accept;

    sync_2ff #(.WIDTH(PTR_W)) u_wr_sync (
        .clk_i (Clk),
        .rst_i (Reset),
        .d_i   (wr_ptr),
        .q_o   (wr_syn_ptr)
    );

    // Empty is judged on the post-read pointer so the last read sets the flag on its own edge.
    always_comb begin
        rd_accept = rd_en & ~empty_q;
        rd_bin_d  = rd_bin_q + PTR_W'(rd_accept);
        rd_ptr_d  = PTR_W'(bin2gray(ptr_word_t'(rd_bin_d)));
        empty_d   = (rd_ptr_d == wr_syn_ptr);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_bin_q <= '0;
            rd_ptr_q <= '0;
            empty_q  <= 1'b1;
        end else begin
            rd_bin_q <= rd_bin_d;
            rd_ptr_q <= rd_ptr_d;
            empty_q  <= empty_d;
        end
    end

    assign rd_ptr     = rd_ptr_q;
    assign rd_addr    = rd_bin_q[a_width-1:0];
    assign empty_flag = empty_q;

`ifdef RD_ALMOST_EMPTY_EN
    logic [PTR_W-1:0] wr_syn_bin;
    logic [PTR_W-1:0] level_d, level_q;
    logic             ae_d, ae_q;

    always_comb begin
        wr_syn_bin = PTR_W'(gray2bin(ptr_word_t'(wr_syn_ptr)));
        level_d    = wr_syn_bin - rd_bin_d;
        ae_d       = (level_d <= PTR_W'(AE_THRESH));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            level_q <= '0;
            ae_q    <= 1'b1;
        end else begin
            level_q <= level_d;
            ae_q    <= ae_d;
        end
    end

    assign rd_level     = level_q;
    assign almost_empty = ae_q;
`endif

endmodule

// File: tb/tb_rd_empty_ctrl.sv
// Randomized and directed bench for rd_empty_ctrl against a count-based reference model.
module tb_rd_empty_ctrl;

    localparam int A = 4;
    localparam int AE = 2;

    logic         clk;
    logic         reset;
    logic         rd_en;
    logic [A:0]   wr_ptr;
    logic [A:0]   rd_ptr;
    logic [A-1:0] rd_addr;
    logic         empty_flag;
`ifdef RD_ALMOST_EMPTY_EN
    logic         almost_empty;
    logic [A:0]   rd_level;
`endif

    rd_empty_ctrl #(
        .a_width (A)
`ifdef RD_ALMOST_EMPTY_EN
        , .AE_THRESH (AE)
`endif
    ) dut (
        .Clk        (clk),
        .Reset      (reset),
        .rd_en      (rd_en),
        .wr_ptr     (wr_ptr),
        .rd_ptr     (rd_ptr),
        .rd_addr    (rd_addr),
        .empty_flag (empty_flag)
`ifdef RD_ALMOST_EMPTY_EN
        ,
        .almost_empty (almost_empty),
        .rd_level     (rd_level)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model state: plain entry counts (binary), synchronizer as two delayed samples
    int unsigned  n_checks = 0;
    int unsigned  n_pass = 0;
    logic [A:0]   m_r;
    logic [A:0]   m_s1, m_s2;
    logic         m_empty;
    logic [A:0]   m_level;
    logic         m_ae;
    logic [A:0]   w_bin;
    logic [A-1:0] exp_q[$];

    function automatic logic [A:0] to_gray(input logic [A:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_edge(input logic en, input logic [A:0] wb, input logic rst);
        logic [A:0] rn;
        if (rst) begin
            m_r = '0; m_s1 = '0; m_s2 = '0;
            m_empty = 1'b1; m_level = '0; m_ae = 1'b1;
        end else begin
            rn = m_r + ((en && !m_empty) ? 5'd1 : 5'd0);
            m_empty = (rn == m_s2);
            m_level = m_s2 - rn;
            m_ae    = (m_level <= AE);
            m_s2    = m_s1;
            m_s1    = wb;
            m_r     = rn;
        end
    endtask

    task automatic check_outputs();
        check("rd_ptr", 32'(rd_ptr), 32'(to_gray(m_r)));
        check("rd_addr", 32'(rd_addr), 32'(m_r[A-1:0]));
        check("empty_flag", 32'(empty_flag), 32'(m_empty));
`ifdef RD_ALMOST_EMPTY_EN
        check("rd_level", 32'(rd_level), 32'(m_level));
        check("almost_empty", 32'(almost_empty), 32'(m_ae));
`endif
    endtask

    // driver: inputs set after the falling edge, outputs sampled at the next falling edge
    task automatic cycle(input logic en, input logic rst);
        rd_en  = en;
        reset  = rst;
        wr_ptr = to_gray(w_bin);
        if (en && !rst && !m_empty) begin
            exp_q.push_back(m_r[A-1:0]);
            check("read_addr", 32'(rd_addr), 32'(exp_q.pop_front()));
        end
        @(posedge clk);
        model_edge(en, w_bin, rst);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        int adv;
        int reads;
        int cyc;
        logic [A-1:0] prev_addr;
        logic saw_msb, saw_wrap;
        logic rst_r, en_r;

        reset = 1'b1; rd_en = 1'b0; wr_ptr = '0; w_bin = '0;
        model_edge(1'b0, '0, 1'b1);

        // reset held two cycles with rd_en high
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        check("rst_rd_ptr", 32'(rd_ptr), 32'd0);
        check("rst_empty", 32'(empty_flag), 32'd1);
`ifdef RD_ALMOST_EMPTY_EN
        check("rst_ae", 32'(almost_empty), 32'd1);
        check("rst_level", 32'(rd_level), 32'd0);
`endif

        // one write: empty clears after the third edge
        w_bin = 5'd1;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        check("lat_empty_k1", 32'(empty_flag), 32'd1);
        cycle(1'b0, 1'b0);
        check("lat_empty_k2", 32'(empty_flag), 32'd0);
`ifdef RD_ALMOST_EMPTY_EN
        check("lat_level", 32'(rd_level), 32'd1);
        check("lat_ae", 32'(almost_empty), 32'd1);
`endif

        // five entries, eight read requests
        w_bin = '0;
        cycle(1'b0, 1'b1);
        w_bin = 5'd5;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
        adv = 0;
        for (int i = 0; i < 8; i++) begin
            prev_addr = rd_addr;
            cycle(1'b1, 1'b0);
            if (rd_addr != prev_addr) begin
                adv++;
                if (adv == 5) check("empty_on_5th", 32'(empty_flag), 32'd1);
            end
        end
        check("advances", 32'(adv), 32'd5);
        check("five_rd_ptr", 32'(rd_ptr), 32'b00111);
        check("five_rd_addr", 32'(rd_addr), 32'd5);

        // streaming 40 reads with the writer ahead
        w_bin = '0;
        cycle(1'b0, 1'b1);
        w_bin = 5'd8;
        reads = 0; cyc = 0; saw_msb = 1'b0; saw_wrap = 1'b0;
        while (reads < 40 && cyc < 300) begin
            if (5'(w_bin - m_r) < 5'd15) w_bin = w_bin + 5'd1;
            prev_addr = rd_addr;
            en_r = 1'b1;
            if (!m_empty) reads++;
            cycle(en_r, 1'b0);
            if (rd_ptr == 5'b10000) saw_msb = 1'b1;
            if (saw_msb && rd_ptr == 5'b00000 && prev_addr == 4'd15) saw_wrap = 1'b1;
            cyc++;
        end
        check("stream_reads", 32'(reads), 32'd40);
        check("stream_wrap", 32'(saw_wrap), 32'd1);

        // full FIFO, then drain to two entries
        w_bin = '0;
        cycle(1'b0, 1'b1);
        w_bin = 5'd16;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
        check("full_empty", 32'(empty_flag), 32'd0);
`ifdef RD_ALMOST_EMPTY_EN
        check("full_level", 32'(rd_level), 32'd16);
        check("full_ae", 32'(almost_empty), 32'd0);
`endif
        for (int i = 0; i < 14; i++) cycle(1'b1, 1'b0);
        check("drain_addr", 32'(rd_addr), 32'd14);
`ifdef RD_ALMOST_EMPTY_EN
        check("drain_level", 32'(rd_level), 32'd2);
        check("drain_ae", 32'(almost_empty), 32'd1);
`endif

        // reset in the middle of a stream
        w_bin = '0;
        cycle(1'b0, 1'b1);
        w_bin = 5'd12;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0);
        check("mid_addr9", 32'(rd_addr), 32'd9);
        cycle(1'b1, 1'b1);
        check("mid_rst_ptr", 32'(rd_ptr), 32'd0);
        check("mid_rst_addr", 32'(rd_addr), 32'd0);
        check("mid_rst_empty", 32'(empty_flag), 32'd1);
        w_bin = '0;
        cycle(1'b0, 1'b0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            rst_r = ($urandom_range(0, 149) == 0);
            if (rst_r) w_bin = '0;
            else if (5'(w_bin - m_r) < 5'd16 && $urandom_range(0, 2) != 0) w_bin = w_bin + 5'd1;
            en_r = 1'($urandom_range(0, 1));
            cycle(en_r, rst_r);
            if (rst_r) exp_q.delete();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
